ysyx_22040759_mem_arbiter: RTL

//  Shares the single AXI read engine and AXI write engine between two requesters: instruction

---
 rtl/ysyx_22040759_mem_arbiter_if.sv | 62 ++++++
 rtl/ysyx_22040759_mem_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040759_mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters (IF, LSU) and the AXI read/write engines.
// Handshakes: a request stays high until its done pulse. The arbiter answers each grant with exactly
// one addr_valid start pulse to an engine. The engine answers with one data_valid pulse when it finishes.
interface ysyx_22040759_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [2:0]        if_size_i;
  logic              if_done_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_err_o;

  logic              lsu_req_i;
  logic              lsu_wen_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [2:0]        lsu_size_i;
  logic [DATA_W-1:0] lsu_wdata_i;
  logic              lsu_done_o;
  logic [DATA_W-1:0] lsu_rdata_o;
  logic              lsu_err_o;

  logic              rd_addr_valid_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [2:0]        rd_size_o;
  logic              rd_data_valid_i;
  logic [DATA_W-1:0] rd_data_i;

  logic              wr_addr_valid_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [2:0]        wr_size_o;
  logic [DATA_W-1:0] wr_data_o;
  logic              wr_data_valid_i;

  logic [2:0]        dbg_state;

  // master: the arbiter itself; slave: requesters and engines around it
  modport master (
    input  if_req_i, if_addr_i, if_size_i,
    output if_done_o, if_rdata_o, if_err_o,
    input  lsu_req_i, lsu_wen_i, lsu_addr_i, lsu_size_i, lsu_wdata_i,
    output lsu_done_o, lsu_rdata_o, lsu_err_o,
    output rd_addr_valid_o, rd_addr_o, rd_size_o,
    input  rd_data_valid_i, rd_data_i,
    output wr_addr_valid_o, wr_addr_o, wr_size_o, wr_data_o,
    input  wr_data_valid_i,
    output dbg_state
  );

  modport slave (
    output if_req_i, if_addr_i, if_size_i,
    input  if_done_o, if_rdata_o, if_err_o,
    output lsu_req_i, lsu_wen_i, lsu_addr_i, lsu_size_i, lsu_wdata_i,
    input  lsu_done_o, lsu_rdata_o, lsu_err_o,
    input  rd_addr_valid_o, rd_addr_o, rd_size_o,
    output rd_data_valid_i, rd_data_i,
    input  wr_addr_valid_o, wr_addr_o, wr_size_o, wr_data_o,
    output wr_data_valid_i,
    input  dbg_state
  );
endinterface

// File: rtl/ysyx_22040759_mem_arbiter.sv
// Round-robin arbiter sharing one AXI read engine and one write engine between IF and LSU.
// One transaction per grant; a stalled engine is aborted after TIMEOUT wait cycles.
module ysyx_22040759_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = $clog2(TIMEOUT)
) (
  input logic clk,
  input logic rst_n,
  ysyx_22040759_mem_arbiter_if.master bus
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_WR_ISSUE = 3'd3;
  localparam logic [2:0] S_WR_WAIT  = 3'd4;
  localparam logic [2:0] S_RESP     = 3'd5;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_LSU = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]        state;
  logic              owner;
  logic              last_grant;
  logic [CNT_W-1:0]  cnt;

  logic              rd_start;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        rd_size;
  logic              wr_start;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_size;
  logic [DATA_W-1:0] wr_data;

  logic              if_done;
  logic              if_err;
  logic [DATA_W-1:0] if_rdata;
  logic              lsu_done;
  logic              lsu_err;
  logic [DATA_W-1:0] lsu_rdata;

  logic              any_req;
  logic              grant_lsu;
  logic              fire;
  logic              fire_err;
  logic [DATA_W-1:0] fire_data;

  assign any_req   = bus.if_req_i | bus.lsu_req_i;
  // On a tie the requester that was not served last wins.
  assign grant_lsu = bus.lsu_req_i & (~bus.if_req_i | (last_grant == OWN_IF));

  always_comb begin
    fire      = 1'b0;
    fire_err  = 1'b0;
    fire_data = '0;
    if (state == S_RD_WAIT) begin
      if (bus.rd_data_valid_i) begin
        fire      = 1'b1;
        fire_data = bus.rd_data_i;
      end else if (cnt == CNT_LAST) begin
        fire     = 1'b1;
        fire_err = 1'b1;
      end
    end else if (state == S_WR_WAIT) begin
      if (bus.wr_data_valid_i) begin
        fire = 1'b1;
      end else if (cnt == CNT_LAST) begin
        fire     = 1'b1;
        fire_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= OWN_IF;
      last_grant <= OWN_LSU;
      cnt        <= '0;
      rd_start   <= 1'b0;
      rd_addr    <= '0;
      rd_size    <= '0;
      wr_start   <= 1'b0;
      wr_addr    <= '0;
      wr_size    <= '0;
      wr_data    <= '0;
      if_done    <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      lsu_done   <= 1'b0;
      lsu_err    <= 1'b0;
      lsu_rdata  <= '0;
    end else begin
      rd_start <= 1'b0;
      wr_start <= 1'b0;
      if_done  <= 1'b0;
      lsu_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner <= grant_lsu ? OWN_LSU : OWN_IF;
            if (grant_lsu && bus.lsu_wen_i) begin
              wr_addr  <= bus.lsu_addr_i;
              wr_size  <= bus.lsu_size_i;
              wr_data  <= bus.lsu_wdata_i;
              wr_start <= 1'b1;
              state    <= S_WR_ISSUE;
            end else begin
              rd_addr  <= grant_lsu ? bus.lsu_addr_i : bus.if_addr_i;
              rd_size  <= grant_lsu ? bus.lsu_size_i : bus.if_size_i;
              rd_start <= 1'b1;
              state    <= S_RD_ISSUE;
            end
          end
        end
        S_RD_ISSUE: begin
          cnt   <= '0;
          state <= S_RD_WAIT;
        end
        S_WR_ISSUE: begin
          cnt   <= '0;
          state <= S_WR_WAIT;
        end
        S_RD_WAIT, S_WR_WAIT: begin
          if (fire) begin
            state <= S_RESP;
            if (owner == OWN_LSU) begin
              lsu_done  <= 1'b1;
              lsu_err   <= fire_err;
              lsu_rdata <= fire_data;
            end else begin
              if_done  <= 1'b1;
              if_err   <= fire_err;
              if_rdata <= fire_data;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          last_grant <= owner;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.if_done_o       = if_done;
  assign bus.if_err_o        = if_err;
  assign bus.if_rdata_o      = if_rdata;
  assign bus.lsu_done_o      = lsu_done;
  assign bus.lsu_err_o       = lsu_err;
  assign bus.lsu_rdata_o     = lsu_rdata;
  assign bus.rd_addr_valid_o = rd_start;
  assign bus.rd_addr_o       = rd_addr;
  assign bus.rd_size_o       = rd_size;
  assign bus.wr_addr_valid_o = wr_start;
  assign bus.wr_addr_o       = wr_addr;
  assign bus.wr_size_o       = wr_size;
  assign bus.wr_data_o       = wr_data;
  assign bus.dbg_state       = state;
endmodule
